alu_nibble_seq: RTL and testbench

Multi-cycle W-bit ALU front end that breaks wide operands into 4-bit nibbles and feeds them, LSB nibble first, through the existing 4-bit ripple adder slice ALU4 (ports A, B, cin, X, cout). It also consumes each slice's sum and carry.
- Registers the inter-nibble carry and assembles the W-bit result and flags.
- Presents the result on a valid/ready handshake.
- Sits between operand/decode logic and the register write-back stage.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_nibble_seq_alu4.sv | 12 +
 rtl/alu_nibble_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_nibble_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared mode codes, widths and sequencer states for the nibble-serial ALU.
package alu_pkg;

   localparam int unsigned MODE_W   = 4;
   localparam int unsigned NIBBLE_W = 4;

   localparam logic [MODE_W-1:0] ADD = 4'd0;
   localparam logic [MODE_W-1:0] SUB = 4'd1;
   localparam logic [MODE_W-1:0] AND = 4'd2;
   localparam logic [MODE_W-1:0] OR  = 4'd3;
   localparam logic [MODE_W-1:0] XOR = 4'd4;
   localparam logic [MODE_W-1:0] NOT = 4'd5;
   localparam logic [MODE_W-1:0] SHL = 4'd6;
   localparam logic [MODE_W-1:0] SHR = 4'd7;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

endpackage

// File: rtl/alu_nibble_seq_alu4.sv
// 4-bit adder slice with carry in/out; one nibble of the serial add/sub datapath.
module ALU4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       cin,
   output logic [3:0] X,
   output logic       cout
);

   assign {cout, X} = {1'b0, A} + {1'b0, B} + {4'b0000, cin};

endmodule

// File: rtl/alu_nibble_seq.sv
// Multi-cycle W-bit ALU: operands are processed one nibble per cycle, LSB first,
// with the result and flags presented on a valid/ready handshake.
module alu_nibble_seq
   import alu_pkg::*;
#(
   parameter int unsigned NIBBLES = 4,
   localparam int unsigned W = NIBBLE_W * NIBBLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MODE_W-1:0] mode,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      x,
   output logic              cout,
   output logic              zero,
   output logic              ovf,
   output logic              err
);

   localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_e              state_q, state_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [W-1:0]        a_q, a_d, b_q, b_d, x_q, x_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                carry_q, carry_d;
   logic                cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;

   int unsigned         off;
   logic [W-1:0]        lres;
   logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib, res_nib;
   logic                slice_cout, is_arith;

   always_comb begin
      off      = 32'(cnt_q) * NIBBLE_W;
      is_arith = (mode_q == ADD) || (mode_q == SUB);
      a_nib    = a_q[off +: NIBBLE_W];
      b_nib    = (mode_q == SUB) ? ~b_q[off +: NIBBLE_W] : b_q[off +: NIBBLE_W];
      // Full-width candidates; only the current nibble is taken each cycle
      unique case (mode_q)
         AND:     lres = a_q & b_q;
         OR:      lres = a_q | b_q;
         XOR:     lres = a_q ^ b_q;
         NOT:     lres = ~a_q;
         SHL:     lres = {a_q[W-2:0], 1'b0};
         SHR:     lres = {1'b0, a_q[W-1:1]};
         default: lres = '0;
      endcase
      res_nib = is_arith ? sum_nib : lres[off +: NIBBLE_W];
   end

   ALU4 u_alu4 (
      .A    (a_nib),
      .B    (b_nib),
      .cin  (carry_q),
      .X    (sum_nib),
      .cout (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      a_d     = a_q;
      b_d     = b_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               mode_d  = mode;
               x_d     = '0;
               cnt_d   = '0;
               carry_d = (mode == SUB);
               cout_d  = 1'b0;
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
               err_d   = 1'b0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // Undefined modes spend a single cycle here so err appears one cycle after accept
            if (mode_q > SHR) begin
               err_d   = 1'b1;
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               x_d[off +: NIBBLE_W] = res_nib;
               carry_d              = slice_cout;
               cnt_d                = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                  cnt_d   = '0;
                  state_d = DONE;
                  zero_d  = (x_d == '0);
                  unique case (mode_q)
                     ADD: begin
                        cout_d = slice_cout;
                        ovf_d  = (a_q[W-1] == b_q[W-1]) && (x_d[W-1] != a_q[W-1]);
                     end
                     SUB: begin
                        cout_d = slice_cout;
                        ovf_d  = (a_q[W-1] != b_q[W-1]) && (x_d[W-1] != a_q[W-1]);
                     end
                     SHL:     cout_d = a_q[W-1];
                     SHR:     cout_d = a_q[0];
                     default: cout_d = 1'b0;
                  endcase
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         x_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         a_q     <= a_d;
         b_q     <= b_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign x         = x_q;
   assign cout      = cout_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed vector table, backpressure and
// mid-operation reset sequences, then random operations against an arithmetic model.
module tb_alu_nibble_seq;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [3:0]   mode = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, cout, zero, ovf, err;
   logic [W-1:0] x;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x         (x),
      .cout      (cout),
      .zero      (zero),
      .ovf       (ovf),
      .err       (err)
   );

   typedef struct {
      logic [3:0]  mode;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] x;
      logic        cout;
      logic        zero;
      logic        ovf;
      logic        err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference built from integer arithmetic and range tests
   function automatic vec_t model(input logic [3:0] m, input logic [15:0] aa, input logic [15:0] bb);
      vec_t r;
      int   sa, sb, s;
      sa     = int'($signed(aa));
      sb     = int'($signed(bb));
      r.mode = m;
      r.a    = aa;
      r.b    = bb;
      r.x    = '0;
      r.cout = 1'b0;
      r.ovf  = 1'b0;
      r.err  = 1'b0;
      case (m)
         4'd0: begin
            r.x    = 16'(int'(aa) + int'(bb));
            r.cout = (int'(aa) + int'(bb)) > 65535;
            s      = sa + sb;
            r.ovf  = (s > 32767) || (s < -32768);
         end
         4'd1: begin
            r.x    = 16'(int'(aa) - int'(bb));
            r.cout = (aa >= bb);
            s      = sa - sb;
            r.ovf  = (s > 32767) || (s < -32768);
         end
         4'd2: r.x = aa & bb;
         4'd3: r.x = aa | bb;
         4'd4: r.x = aa ^ bb;
         4'd5: r.x = ~aa;
         4'd6: begin
            r.x    = 16'(int'(aa) * 2);
            r.cout = aa >= 16'h8000;
         end
         4'd7: begin
            r.x    = aa / 16'd2;
            r.cout = (aa % 16'd2) == 16'd1;
         end
         default: r.err = 1'b1;
      endcase
      r.zero = (r.x == 16'h0000);
      return r;
   endfunction

   task automatic run_op(input vec_t v, input int hold, input string tag);
      int           cyc;
      int           lat;
      logic [15:0]  hx;
      logic [3:0]   hf;
      lat = v.err ? 1 : NIBBLES;
      @(negedge clk);
      check({tag, ".in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      mode     = v.mode;
      a        = v.a;
      b        = v.b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      mode     = 4'($urandom);
      cyc      = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, ".latency"}, cyc, lat);
      check({tag, ".x"}, x, v.x);
      check({tag, ".cout"}, cout, v.cout);
      check({tag, ".zero"}, zero, v.zero);
      check({tag, ".ovf"}, ovf, v.ovf);
      check({tag, ".err"}, err, v.err);
      check({tag, ".in_ready_busy"}, in_ready, 0);
      hx = x;
      hf = {cout, zero, ovf, err};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         mode     = 4'd0;
         a        = 16'($urandom);
         b        = 16'($urandom);
         @(posedge clk);
         #1;
         check({tag, ".hold_valid"}, out_valid, 1);
         check({tag, ".hold_x"}, x, hx);
         check({tag, ".hold_flags"}, {cout, zero, ovf, err}, hf);
         check({tag, ".hold_in_ready"}, in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".released"}, out_valid, 0);
   endtask

   vec_t tbl[11];

   initial begin
      vec_t v;
      tbl[0]  = '{4'd0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{4'd1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{4'd6, 16'h8421, 16'h0000, 16'h0842, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'd7, 16'h8421, 16'h0000, 16'h4210, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{4'd3, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{4'd4, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{4'd5, 16'hF0F0, 16'h3C3C, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{4'hA, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("reset.in_ready", in_ready, 1);
      check("reset.out_valid", out_valid, 0);
      check("reset.x", x, 0);
      check("reset.flags", {cout, zero, ovf, err}, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_op(tbl[i], 0, $sformatf("vec%0d", i));
      end

      run_op(tbl[2], 5, "backpressure");

      // Reset asserted during the second EXEC cycle
      @(negedge clk);
      in_valid = 1'b1;
      mode     = 4'd0;
      a        = 16'h1234;
      b        = 16'h1111;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst.out_valid", out_valid, 0);
      check("midrst.in_ready", in_ready, 1);
      check("midrst.x", x, 0);
      check("midrst.flags", {cout, zero, ovf, err}, 0);
      @(negedge clk);
      rst = 1'b0;
      run_op(model(4'd0, 16'h0001, 16'h0001), 0, "after_rst");

      for (int i = 0; i < 150; i++) begin
         v = model(4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom));
         run_op(v, ($urandom_range(0, 7) == 0) ? 2 : 0, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
